aes_round_ctrl: RTL

Round sequencer for the AES-128 encryption datapath. It accepts the one-cycle load strobe from the 32-bit-to-128-bit input buffer and drives the round datapath: initial AddRoundKey load, key-expansion advance, Rcon, and MixColumns bypass in the final round. It holds the result under a valid/ready handshake, then returns a done pulse to the input buffer so the buffer can collect the next block.

---
 rtl/aes_ctrl_pkg.sv | 26 ++
 rtl/aes_rcon_gen.sv | 26 ++
 rtl/aes_round_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES-128 round sequencer.
// Build macro AES_CTRL_STALL_EN enables the datapath stall input.
package aes_ctrl_pkg;

  localparam int RW = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    HOLD,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reset/init to 01,
// multiply by x in GF(2^8) on each advance.
module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_init,
  input  logic       i_adv,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk) begin
    if (!rst)
      r_rcon <= RCON_INIT;
    else if (i_init)
      r_rcon <= RCON_INIT;
    else if (i_adv)
      r_rcon <= xtime(r_rcon);
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer (LOAD, NR rounds, HOLD, DONE).
// Build macro AES_CTRL_STALL_EN adds the stall_i input.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         out_ready_i,
`ifdef AES_CTRL_STALL_EN
  input  logic         stall_i,
`endif
  output logic         ld_dp_o,
  output logic [RW-1:0] round_o,
  output logic         kexp_en_o,
  output logic [7:0]   rcon_o,
  output logic         sub_en_o,
  output logic         mix_en_o,
  output logic         final_o,
  output logic         busy_o,
  output logic         out_valid_o,
  output logic         done_o,
  output logic         ovf_o
);

  localparam logic [RW-1:0] R_LAST = RW'(NR - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_round;
  logic [RW-1:0] w_round_nxt;
  logic          r_ovf;
  logic          w_stall;
  logic          w_init;
  logic          w_adv;
  logic [7:0]    w_rcon;

`ifdef AES_CTRL_STALL_EN
  assign w_stall = stall_i;
`else
  assign w_stall = 1'b0;
`endif

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .rst    (rst),
    .i_init (w_init),
    .i_adv  (w_adv),
    .o_rcon (w_rcon)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_round <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      if (ld_i && r_state != IDLE &&
          r_state != DONE)
        r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_init      = 1'b0;
    w_adv       = 1'b0;
    ld_dp_o     = 1'b0;
    round_o     = '0;
    kexp_en_o   = 1'b0;
    rcon_o      = 8'h00;
    sub_en_o    = 1'b0;
    mix_en_o    = 1'b0;
    final_o     = 1'b0;
    busy_o      = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_init = 1'b1;
        if (ld_i)
          w_state_nxt = LOAD;
      end
      LOAD: begin
        busy_o  = 1'b1;
        ld_dp_o = !w_stall;
        w_init  = 1'b1;
        if (!w_stall) begin
          w_state_nxt = ROUND;
          w_round_nxt = R_ONE;
        end
      end
      ROUND: begin
        busy_o    = 1'b1;
        round_o   = r_round;
        rcon_o    = w_rcon;
        sub_en_o  = !w_stall;
        mix_en_o  = !w_stall;
        kexp_en_o = !w_stall;
        if (!w_stall) begin
          w_adv       = 1'b1;
          w_round_nxt = r_round + R_ONE;
          if (r_round == R_LAST)
            w_state_nxt = FINAL;
        end
      end
      FINAL: begin
        busy_o    = 1'b1;
        round_o   = r_round;
        rcon_o    = w_rcon;
        final_o   = 1'b1;
        sub_en_o  = !w_stall;
        kexp_en_o = !w_stall;
        if (!w_stall)
          w_state_nxt = HOLD;
      end
      HOLD: begin
        busy_o      = 1'b1;
        round_o     = r_round;
        out_valid_o = 1'b1;
        w_init      = 1'b1;
        if (out_ready_i) begin
          w_state_nxt = DONE;
          w_round_nxt = '0;
        end
      end
      DONE: begin
        done_o = 1'b1;
        w_init = 1'b1;
        w_state_nxt = ld_i ? LOAD : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_round_nxt = '0;
      end
    endcase
  end

endmodule
